// File: rtl/fmap_bram.sv
// rtl/fmap_bram.sv - channel-planar feature-map RAM with raster frame loader and zero-padding reads
// Define FMAP_OUT_REG_EN to add an output register stage (read latency 2 instead of 1).
module fmap_bram #(
   parameter  int DATA_W = 8,
   parameter  int IMG_W  = 64,
   parameter  int IMG_H  = 64,
   parameter  int CH     = 4,
   localparam int CW     = (CH > 1) ? $clog2(CH) : 1,
   localparam int RW     = $clog2(IMG_H) + 1,
   localparam int XW     = $clog2(IMG_W) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ld_start,
   input  logic                     ld_valid,
   input  logic [DATA_W-1:0]        ld_data,
   output logic                     ld_ready,
   output logic                     frame_done,
   input  logic                     rd_en,
   input  logic [CW-1:0]            rd_ch,
   input  logic signed [RW-1:0]     rd_row,
   input  logic signed [XW-1:0]     rd_col,
   output logic                     rd_valid,
   output logic [DATA_W-1:0]        rd_data
);

   localparam int DEPTH = CH * IMG_H * IMG_W;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int RCW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int XCW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [RW:0] ROW_LIM = (RW+1)'(IMG_H);
   localparam logic [XW:0] COL_LIM = (XW+1)'(IMG_W);

   logic [DATA_W-1:0] mem [0:DEPTH-1] = '{default: '0};

   logic [1:0]     state;
   logic [CW-1:0]  ch_cnt;
   logic [RCW-1:0] row_cnt;
   logic [XCW-1:0] col_cnt;
   logic           beat;
   logic           col_last;
   logic           row_last;
   logic           ch_last;
   logic [AW-1:0]  wr_addr;

   assign ld_ready   = (state == LOAD);
   assign frame_done = (state == DONE);
   assign beat       = (state == LOAD) && ld_valid;
   assign col_last   = (col_cnt == XCW'(IMG_W - 1));
   assign row_last   = (row_cnt == RCW'(IMG_H - 1));
   assign ch_last    = (ch_cnt  == CW'(CH - 1));
   assign wr_addr    = AW'(ch_cnt) * AW'(IMG_H * IMG_W) + AW'(row_cnt) * AW'(IMG_W) + AW'(col_cnt);

   // Raster order: col fastest, then row, then channel plane.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         ch_cnt  <= '0;
         row_cnt <= '0;
         col_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (ld_start) begin
                  state   <= LOAD;
                  ch_cnt  <= '0;
                  row_cnt <= '0;
                  col_cnt <= '0;
               end
            end
            LOAD: begin
               if (ld_valid) begin
                  if (col_last) begin
                     col_cnt <= '0;
                     if (row_last) begin
                        row_cnt <= '0;
                        if (ch_last) begin
                           ch_cnt <= '0;
                           state  <= DONE;
                        end else begin
                           ch_cnt <= ch_cnt + CW'(1);
                        end
                     end else begin
                        row_cnt <= row_cnt + RCW'(1);
                     end
                  end else begin
                     col_cnt <= col_cnt + XCW'(1);
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (beat) mem[wr_addr] <= ld_data;
   end

   logic          row_oob;
   logic          col_oob;
   logic          ch_oob;
   logic          pad;
   logic [AW-1:0] rd_addr;

   // Zero-extended compare covers the upper bound; the sign bit covers negatives.
   assign row_oob = rd_row[RW-1] | ({1'b0, rd_row} >= ROW_LIM);
   assign col_oob = rd_col[XW-1] | ({1'b0, rd_col} >= COL_LIM);

   generate
      if (CH == (1 << CW)) begin : g_ch_full
         assign ch_oob = 1'b0;
      end else begin : g_ch_part
         localparam logic [CW:0] CH_LIM = (CW+1)'(CH);
         assign ch_oob = ({1'b0, rd_ch} >= CH_LIM);
      end
   endgenerate

   assign pad     = row_oob | col_oob | ch_oob;
   assign rd_addr = AW'(rd_ch) * AW'(IMG_H * IMG_W) + AW'($unsigned(rd_row)) * AW'(IMG_W)
                  + AW'($unsigned(rd_col));

`ifdef FMAP_OUT_REG_EN
   logic              s1_valid;
   logic              s1_pad;
   logic [DATA_W-1:0] s1_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_pad   <= 1'b0;
         s1_data  <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         s1_valid <= rd_en;
         if (rd_en) begin
            s1_pad <= pad;
            if (!pad) s1_data <= mem[rd_addr];
         end
         rd_valid <= s1_valid;
         if (s1_valid) rd_data <= s1_pad ? '0 : s1_data;
      end
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            if (pad) rd_data <= '0;
            else     rd_data <= mem[rd_addr];
         end
      end
   end
`endif

endmodule

// File: tb/tb_fmap_bram.sv
// tb/tb_fmap_bram.sv - self-checking bench for fmap_bram against an array reference model
module tb_fmap_bram;

   localparam int DATA_W = 8;
   localparam int IMG_W  = 64;
   localparam int IMG_H  = 64;
   localparam int CH     = 4;
   localparam int CW     = 2;
   localparam int RW     = 7;
   localparam int XW     = 7;
   localparam int DEPTH  = CH * IMG_H * IMG_W;
`ifdef FMAP_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              ld_start;
   logic              ld_valid;
   logic [DATA_W-1:0] ld_data;
   logic              ld_ready;
   logic              frame_done;
   logic              rd_en;
   logic [CW-1:0]     rd_ch;
   logic signed [RW-1:0] rd_row;
   logic signed [XW-1:0] rd_col;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;

   fmap_bram dut (
      .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
      .ld_ready(ld_ready), .frame_done(frame_done), .rd_en(rd_en), .rd_ch(rd_ch),
      .rd_row(rd_row), .rd_col(rd_col), .rd_valid(rd_valid), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [7:0] model_mem [DEPTH];
   bit         qv [$];
   logic [7:0] qd [$];
   logic [7:0] hold;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One read-port cycle; expected value comes from the array model at issue time.
   task automatic rd_cycle(input bit en, input int ch, input int row, input int col);
      logic [CW-1:0]        c;
      logic signed [RW-1:0] r;
      logic signed [XW-1:0] x;
      bit                   ev;
      logic [7:0]           ed;
      c = CW'(ch);
      r = RW'(row);
      x = XW'(col);
      rd_en = en; rd_ch = c; rd_row = r; rd_col = x;
      if (en) begin
         if (int'(r) < 0 || int'(r) >= IMG_H || int'(x) < 0 || int'(x) >= IMG_W || int'(c) >= CH)
            hold = 8'h00;
         else
            hold = model_mem[int'(c) * IMG_H * IMG_W + int'(r) * IMG_W + int'(x)];
      end
      qv.push_back(en);
      qd.push_back(hold);
      step();
      rd_en = 1'b0;
      if (qv.size() >= LAT) begin
         ev = qv.pop_front();
         ed = qd.pop_front();
         chk("rd_valid", 32'(rd_valid), 32'(ev));
         chk("rd_data", 32'(rd_data), 32'(ed));
      end
   endtask

   task automatic read1(input int ch, input int row, input int col);
      rd_cycle(1'b1, ch, row, col);
      repeat (LAT) rd_cycle(1'b0, 0, 0, 0);
   endtask

   task automatic rand_reads(input int n);
      for (int k = 0; k < n; k++)
         rd_cycle(($urandom % 4) != 0, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 79)) - 8, int'($urandom_range(0, 79)) - 8);
      repeat (LAT) rd_cycle(1'b0, 0, 0, 0);
   endtask

   initial begin
      int  early;
      int  accepted;
      int  cyc;
      int  a;
      bit  acc;
      logic fd_at_end;

      for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
      hold = 8'h00;
      rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
      rd_en = 1'b0; rd_ch = '0; rd_row = '0; rd_col = '0;

      #7;
      chk("rst_ld_ready", 32'(ld_ready), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_rd_valid", 32'(rd_valid), 0);
      chk("rst_rd_data", 32'(rd_data), 0);
      #16 rst = 1'b0;
      step();

      // ld_valid in IDLE must not load anything
      ld_valid = 1'b1; ld_data = 8'hAA;
      step(); step();
      chk("idle_ld_ready", 32'(ld_ready), 0);
      chk("idle_frame_done", 32'(frame_done), 0);
      ld_valid = 1'b0;
      read1(0, 0, 0);

      // full frame load, ld_valid held high
      ld_start = 1'b1; step(); ld_start = 1'b0;
      chk("s1_ld_ready", 32'(ld_ready), 1);
      ld_valid = 1'b1;
      early = 0;
      for (int i = 0; i < DEPTH; i++) begin
         ld_data = 8'(i);
         step();
         model_mem[i] = 8'(i);
         if (i < DEPTH - 1 && frame_done) early++;
      end
      chk("s1_fd_after_last", 32'(frame_done), 1);
      chk("s1_ready_in_done", 32'(ld_ready), 0);
      step();
      chk("s1_fd_one_cycle", 32'(frame_done), 0);
      chk("s1_ready_after", 32'(ld_ready), 0);
      step();
      chk("s1_fd_stays_low", 32'(frame_done), 0);
      ld_valid = 1'b0;
      chk("s1_early_fd", 32'(early), 0);

      // directed reads and padding
      read1(1, 0, 1);
      read1(3, 63, 63);
      read1(0, 0, 0);
      read1(0, -1, 5);
      read1(0, 10, 64);
      read1(0, 64, 0);
      read1(2, 5, -3);
      for (int k = 0; k < 4; k++) rd_cycle(1'b1, k, k * 7, 63 - k);
      repeat (LAT) rd_cycle(1'b0, 0, 0, 0);
      rand_reads(200);

      // partial load then asynchronous reset
      ld_start = 1'b1; step(); ld_start = 1'b0;
      ld_valid = 1'b1;
      rd_en = 1'b1; rd_ch = '0; rd_row = '0; rd_col = 7'sd1;
      for (int i = 0; i < 100; i++) begin
         ld_data = ~8'(i);
         step();
         model_mem[i] = ~8'(i);
      end
      chk("s5_pre_rd_valid", 32'(rd_valid), 1);
      chk("s5_pre_rd_nonzero", 32'(rd_data != 8'h00), 1);
      #2 rst = 1'b1;
      #1;
      chk("s5_async_ld_ready", 32'(ld_ready), 0);
      chk("s5_async_frame_done", 32'(frame_done), 0);
      chk("s5_async_rd_valid", 32'(rd_valid), 0);
      chk("s5_async_rd_data", 32'(rd_data), 0);
      ld_valid = 1'b0; rd_en = 1'b0;
      qv.delete(); qd.delete(); hold = 8'h00;
      step();
      #2 rst = 1'b0;
      step();
      chk("s5_idle_ready", 32'(ld_ready), 0);
      ld_valid = 1'b1;
      step();
      chk("s5_no_load", 32'(ld_ready), 0);
      chk("s5_no_fd", 32'(frame_done), 0);
      ld_valid = 1'b0;
      read1(0, 1, 35);
      read1(0, 1, 36);
      read1(0, 0, 1);

      // reload with random ld_valid gaps and an ignored mid-load ld_start
      ld_start = 1'b1; step(); ld_start = 1'b0;
      accepted = 0; cyc = 0; early = 0; fd_at_end = 1'b0;
      while (accepted < DEPTH && cyc < 40000) begin
         ld_valid = $urandom_range(0, 1) == 1;
         ld_data  = 8'(accepted);
         ld_start = (cyc == 300);
         acc = ld_valid && ld_ready;
         a = accepted;
         if (cyc < 150)
            rd_cycle(1'b1, a / (IMG_H * IMG_W), (a / IMG_W) % IMG_H, a % IMG_W);
         else if (cyc < 600)
            rd_cycle($urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 70)) - 3, int'($urandom_range(0, 70)) - 3);
         else
            step();
         if (acc) begin
            model_mem[accepted] = 8'(accepted);
            accepted++;
         end
         if (acc && accepted == DEPTH) fd_at_end = frame_done;
         else if (frame_done) early++;
         cyc++;
      end
      ld_valid = 1'b0; ld_start = 1'b0;
      repeat (LAT) rd_cycle(1'b0, 0, 0, 0);
      chk("s4_completed", 32'(accepted), DEPTH);
      chk("s4_fd_at_end", 32'(fd_at_end), 1);
      chk("s4_early_fd", 32'(early), 0);
      chk("s4_fd_cleared", 32'(frame_done), 0);
      chk("s4_ready_after", 32'(ld_ready), 0);
      read1(0, 1, 35);
      read1(0, 1, 36);
      read1(1, 0, 1);
      read1(3, 63, 63);
      rand_reads(300);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
